apb_sram_arbiter: RTL and testbench
===================================

// Module: apb_sram_arbiter
// PURPOSE
//  APB master-side arbiter/sequencer sharing one APB SRAM slave among NUM_REQ requesters.
//  Round-robin grants requests, runs the APB SETUP/ACCESS protocol, returns read data or error.
//  Adds a PREADY timeout so a hung slave cannot lock the bus.
//  Sits between requester engines and the apb_sram_if master modport.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..16)
//  TIMEOUT  16  max ACCESS cycles waiting for PREADY; 0 = timeout disabled
// PORTS
//  PCLK        in   1                   clock
//  PRESET      in   1                   synchronous, active-high reset
//  req_valid   in   NUM_REQ             per-requester request pending
//  req_write   in   NUM_REQ             1 = write, 0 = read
//  req_addr    in   NUM_REQ x apb_addr_t  per-requester address
//  req_wdata   in   NUM_REQ x apb_data_t  per-requester write data
//  req_ready   out  NUM_REQ             one-hot accept pulse
//  resp_valid  out  NUM_REQ             one-hot completion pulse
//  resp_rdata  out  apb_data_t          read data, valid with resp_valid
//  resp_err    out  1                   PSLVERR or timeout, valid with resp_valid
//  PADDR/PSEL/PENABLE/PWRITE/PWDATA  out  APB request (apb_addr_t/1/1/1/apb_data_t)
//  PREADY/PSLVERR/PRDATA             in   APB response (1/1/apb_data_t)
// BEHAVIOUR
//  - All outputs registered. Reset: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, req_ready=0,
//    resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, RR pointer -> requester 0 highest.
//  - FSM IDLE/SETUP/ACCESS.
//    IDLE: if |req_valid, grant g = first valid at or after pointer (wrap); latch addr/write/wdata;
//      req_ready[g]=1 for one cycle; next PSEL=1, PENABLE=0 -> SETUP; pointer = g+1 mod NUM_REQ.
//    SETUP -> ACCESS unconditionally; PENABLE=1.
//    ACCESS: hold PADDR/PWRITE/PWDATA/PSEL stable. On PREADY: resp_valid[g]=1 next cycle,
//      resp_err=PSLVERR, resp_rdata=PRDATA for reads, 0 for writes; PENABLE=0.
//      If any req_valid in that cycle, arbitrate as IDLE and go straight to SETUP (PSEL stays 1,
//      back-to-back); else PSEL=0 -> IDLE.
//  - Latency: request accepted in cycle N -> SETUP N+1 -> ACCESS N+2 -> resp_valid N+3 when zero-wait.
//  - PWDATA = latched wdata on writes, 0 on reads.
//  - Requester may drop req_valid before its req_ready; after accept, its req_* is don't-care.
//  - A requester must not re-request before its resp_valid; a new req_valid from it meanwhile is ignored.
//  - Timeout: counter cleared on entering ACCESS, increments each ACCESS cycle without PREADY.
//    At count==TIMEOUT-1 without PREADY: complete with resp_err=1, resp_rdata=0, PSEL=PENABLE=0.
//    PREADY in that same cycle wins (normal completion).
//  - Requesters that are not granted keep req_valid high; RR guarantees service within NUM_REQ grants.
//  - Reset mid-transfer: outputs return to reset values next edge; no resp_valid issued.
//  - PSEL never X/Z out of reset; PENABLE=1 only when PSEL=1 in ACCESS.
// STRUCTURE
//  - apb_sram_pkg adds: apb_arb_state_e {IDLE,SETUP,ACCESS}; REQ_IDX_W function/const (clog2).
//  - Reuse apb_addr_t/apb_data_t; APB side connects to apb_sram_if.master.
//  - Sub-module apb_rr_arbiter: combinational req vector + pointer -> one-hot grant + index.
//  - SVA: PENABLE implies PSEL; request fields stable from SETUP to completion; $onehot0 on req_ready/resp_valid.
// TESTING
//  1 Reset: PRESET=1 for 3 cycles -> all outputs 0; PSEL known (not X) from first post-reset edge.
//  2 Single write: req 0 write addr 0x10 data 0xA5A5_0001, PREADY=1 -> SETUP, ACCESS, resp_valid[0]
//    3 cycles after accept, resp_err=0; then read 0x10 -> resp_rdata=0xA5A5_0001.
//  3 All 4 valid continuously -> grant order 0,1,2,3,0; back-to-back transfers with no IDLE cycle.
//  4 Wait states: PREADY low 3 ACCESS cycles -> PADDR/PWDATA stable; completes on 4th; PSLVERR=1 -> resp_err=1.
//  5 Timeout: TIMEOUT=16, PREADY never high -> resp_err=1, resp_rdata=0 after 16 ACCESS cycles; bus returns to IDLE.
//  6 PRESET asserted in ACCESS with req 2 active -> no resp_valid[2]; PSEL=0 next edge; RR pointer at 0.

Source files
------------

// File: rtl/apb_sram_pkg.sv
// rtl/apb_sram_pkg.sv - shared APB SRAM types, arbiter state encoding and index-width helper
//
// Purpose : common types for the APB SRAM arbiter slice.
// Contents: apb_addr_t / apb_data_t bus types, apb_arb_state_e FSM encoding,
//           req_idx_w() width of a requester index.
package apb_sram_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef logic [APB_AW-1:0] apb_addr_t;
    typedef logic [APB_DW-1:0] apb_data_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS
    } apb_arb_state_e;

    // A single-requester index still needs one bit to stay a legal vector.
    function automatic int req_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin pick: first request at or after the pointer
//
// Purpose : combinational round-robin selection.
// Ports   : req  in  NUM_REQ  pending requests
//           ptr  in  IW       highest-priority requester this round
//           gnt  out NUM_REQ  one-hot grant (zero when no request)
//           idx  out IW       binary index of the granted requester
//           any  out 1        at least one request present
module apb_rr_arbiter
    import apb_sram_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW:0]   pos;
    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        pos  = '0;
        cand = '0;
        // Walk from the pointer upward, wrapping once; the first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            cand = pos[IW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_sram_arbiter.sv
// rtl/apb_sram_arbiter.sv - round-robin APB master sequencer sharing one SRAM slave among requesters
//
// Purpose : grants requesters round-robin, runs APB SETUP/ACCESS, returns read data or
//           error, and aborts a transfer whose PREADY never arrives.
// Ports   : PCLK, PRESET (sync, active high)
//           req_valid/req_write/req_addr/req_wdata  in   per-requester request
//           req_ready                               out  one-hot accept pulse
//           resp_valid/resp_rdata/resp_err          out  one-hot completion, data, error
//           PADDR/PSEL/PENABLE/PWRITE/PWDATA        out  APB request
//           PREADY/PSLVERR/PRDATA                   in   APB response
module apb_sram_arbiter
    import apb_sram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  apb_addr_t [NUM_REQ-1:0] req_addr,
    input  apb_data_t [NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output apb_data_t               resp_rdata,
    output logic                    resp_err,
    output apb_addr_t               PADDR,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output apb_data_t               PWDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  apb_data_t               PRDATA
);

    localparam int IW = req_idx_w(NUM_REQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_arb_state_e     state;
    logic [IW-1:0]      ptr;
    logic [NUM_REQ-1:0] cur_gnt;
    logic [TW-1:0]      tcnt;

    logic [NUM_REQ-1:0] eff_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               timed_out;
    logic               take;

    // The requester still in flight cannot win again until its response has gone out.
    assign eff_req   = req_valid & ((state == IDLE) ? {NUM_REQ{1'b1}} : ~cur_gnt);
    assign timed_out = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    assign take      = arb_any && ((state == IDLE) || ((state == ACCESS) && PREADY));

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (eff_req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            ptr        <= '0;
            cur_gnt    <= '0;
            tcnt       <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            PADDR      <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    tcnt    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        resp_valid <= cur_gnt;
                        resp_err   <= PSLVERR;
                        resp_rdata <= PWRITE ? '0 : PRDATA;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        state      <= IDLE;
                    end else if (timed_out) begin
                        resp_valid <= cur_gnt;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A grant overrides the return to IDLE so back-to-back transfers keep PSEL high.
            if (take) begin
                req_ready <= arb_gnt;
                cur_gnt   <= arb_gnt;
                PADDR     <= req_addr[arb_idx];
                PWRITE    <= req_write[arb_idx];
                PWDATA    <= req_write[arb_idx] ? req_wdata[arb_idx] : '0;
                PSEL      <= 1'b1;
                PENABLE   <= 1'b0;
                state     <= SETUP;
                ptr       <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    a_penable_psel: assert property (@(posedge PCLK) disable iff (PRESET)
        PENABLE |-> PSEL);
    a_fields_stable: assert property (@(posedge PCLK) disable iff (PRESET)
        (PSEL && PENABLE) |-> $stable({PADDR, PWRITE, PWDATA}));
    a_ready_onehot: assert property (@(posedge PCLK) disable iff (PRESET)
        $onehot0(req_ready));
    a_resp_onehot: assert property (@(posedge PCLK) disable iff (PRESET)
        $onehot0(resp_valid));

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// tb/tb_apb_sram_arbiter.sv - self-checking bench for apb_sram_arbiter with SRAM slave and reference model
module tb_apb_sram_arbiter;
    import apb_sram_pkg::*;

    logic                PCLK = 1'b0;
    logic                PRESET = 1'b1;
    logic [3:0]          req_valid = '0;
    logic [3:0]          req_write = '0;
    apb_addr_t [3:0]     req_addr = '0;
    apb_data_t [3:0]     req_wdata = '0;
    logic [3:0]          req_ready;
    logic [3:0]          resp_valid;
    apb_data_t           resp_rdata;
    logic                resp_err;
    apb_addr_t           PADDR;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    apb_data_t           PWDATA;
    logic                PREADY;
    logic                PSLVERR;
    apb_data_t           PRDATA;

    int checks = 0;
    int errors = 0;

    apb_sram_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // SRAM slave: errors on the top 16 bytes, configurable wait states, optional hang.
    logic [31:0] mem [256];
    int          acc_cnt = 0;
    int          wait_cfg = 0;
    bit          hang = 1'b0;

    assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_cfg);
    assign PSLVERR = (PADDR[7:0] >= 8'hF0);
    assign PRDATA  = mem[PADDR[7:0]];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) mem[PADDR[7:0]] <= PWDATA;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference round-robin: first request at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic apply_reset(input int n);
        @(negedge PCLK);
        PRESET = 1'b1;
        repeat (n) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic idle_bus();
        req_valid = '0;
        repeat (8) @(negedge PCLK);
    endtask

    // One transaction from requester r; reports latency (req_ready -> resp_valid in cycles),
    // ACCESS cycles seen, field stability during ACCESS and whether SETUP looked right.
    task automatic do_txn(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int acc, output bit stab, output bit setup_ok,
                          output logic [31:0] rd, output logic er, output bit got);
        bit gr = 1'b0;
        got = 1'b0; acc = 0; stab = 1'b1; setup_ok = 1'b0; lat = 0; rd = '0; er = 1'b0;
        req_write[r] = wr; req_addr[r] = a; req_wdata[r] = d; req_valid[r] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (req_ready[r]) begin
                gr = 1'b1;
                setup_ok = PSEL && !PENABLE;
                break;
            end
        end
        req_valid[r] = 1'b0;
        if (!gr) return;
        for (int k = 1; k < 40; k++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                acc++;
                if (PADDR !== a || PWRITE !== wr || PWDATA !== (wr ? d : 32'h0)) stab = 1'b0;
            end
            if (resp_valid[r]) begin
                lat = k; rd = resp_rdata; er = resp_err; got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 000", {PSEL, PENABLE, PWRITE});
        end
        checks++;
        if (PADDR !== '0 || PWDATA !== '0) begin
            errors++; $display("FAIL reset_bus: got PADDR=%h PWDATA=%h exp 0", PADDR, PWDATA);
        end
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp: got rdy=%b rv=%b rd=%h er=%b exp 0",
                               req_ready, resp_valid, resp_rdata, resp_err);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b0) begin
            errors++; $display("FAIL reset_psel_known: got %b exp 0", PSEL);
        end
    endtask

    task automatic test_single();
        int lat, acc; bit stab, su, got; logic [31:0] rd; logic er;
        wait_cfg = 0;
        do_txn(0, 1'b1, 32'h10, 32'hA5A5_0001, lat, acc, stab, su, rd, er, got);
        checks++;
        if (!got || lat != 2 || er !== 1'b0) begin
            errors++; $display("FAIL single_write: got done=%0d lat=%0d err=%b exp 1/2/0", got, lat, er);
        end
        checks++;
        if (!su || acc != 1 || !stab) begin
            errors++; $display("FAIL single_write_phase: got setup=%0d acc=%0d stable=%0d exp 1/1/1", su, acc, stab);
        end
        do_txn(0, 1'b0, 32'h10, 32'h0, lat, acc, stab, su, rd, er, got);
        checks++;
        if (!got || rd !== 32'hA5A5_0001 || er !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL single_read: got done=%0d rd=%h err=%b lat=%0d exp 1/a5a50001/0/2",
                               got, rd, er, lat);
        end
        idle_bus();
    endtask

    task automatic test_round_robin();
        int gr_idx[5]; int gr_cyc[5]; int n = 0; int gaps = 0; int cyc = 0;
        logic [3:0] mask; int p; int e; int bad_iv = 0;
        apply_reset(2);
        wait_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            req_write[i] = 1'b1; req_addr[i] = 32'h40 + 4 * i; req_wdata[i] = $urandom;
        end
        req_valid = 4'hF;
        while (n < 5 && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (n > 0 && !PSEL) gaps++;
            if (req_ready != '0) begin
                gr_idx[n] = idx_of(req_ready); gr_cyc[n] = cyc; n++;
            end
        end
        req_valid = '0;
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL rr_count: got %0d grants exp 5", n);
        end
        p = 0; mask = 4'h0;
        for (int k = 0; k < n; k++) begin
            e = pick(4'hF & ~mask, p);
            checks++;
            if (gr_idx[k] != e) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d exp %0d", k, gr_idx[k], e);
            end
            mask = 4'h1 << e; p = (e + 1) % 4;
            if (k > 0 && gr_cyc[k] - gr_cyc[k-1] != 2) bad_iv++;
        end
        checks++;
        if (gaps != 0 || bad_iv != 0) begin
            errors++; $display("FAIL rr_back_to_back: got idle=%0d bad_interval=%0d exp 0/0", gaps, bad_iv);
        end
        idle_bus();
    endtask

    task automatic test_wait_states();
        int lat, acc; bit stab, su, got; logic [31:0] rd; logic er;
        logic [31:0] d = $urandom;
        wait_cfg = 3;
        do_txn(1, 1'b1, 32'hF4, d, lat, acc, stab, su, rd, er, got);
        checks++;
        if (!got || acc != 4 || !stab || lat != 5) begin
            errors++; $display("FAIL wait_write: got done=%0d acc=%0d stable=%0d lat=%0d exp 1/4/1/5",
                               got, acc, stab, lat);
        end
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL wait_pslverr: got %b exp 1", er);
        end
        do_txn(3, 1'b0, 32'h18, 32'h0, lat, acc, stab, su, rd, er, got);
        checks++;
        if (!got || rd !== 32'hC0DE_0018 || er !== 1'b0 || acc != 4) begin
            errors++; $display("FAIL wait_read: got done=%0d rd=%h err=%b acc=%0d exp 1/c0de0018/0/4",
                               got, rd, er, acc);
        end
        wait_cfg = 0;
        idle_bus();
    endtask

    task automatic test_timeout();
        int lat, acc; bit stab, su, got; logic [31:0] rd; logic er;
        wait_cfg = 0;
        do_txn(2, 1'b1, 32'h20, 32'h1234_5678, lat, acc, stab, su, rd, er, got);
        hang = 1'b1;
        do_txn(2, 1'b0, 32'h20, 32'h0, lat, acc, stab, su, rd, er, got);
        checks++;
        if (!got || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL timeout_resp: got done=%0d err=%b rd=%h exp 1/1/0", got, er, rd);
        end
        checks++;
        if (acc != 16 || lat != 17) begin
            errors++; $display("FAIL timeout_len: got acc=%0d lat=%0d exp 16/17", acc, lat);
        end
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: got PSEL=%b PENABLE=%b exp 0/0", PSEL, PENABLE);
        end
        hang = 1'b0;
        idle_bus();
    endtask

    task automatic test_reset_mid();
        bit gr = 1'b0; bit seen = 1'b0; int first = -1;
        hang = 1'b1;
        req_write[2] = 1'b0; req_addr[2] = 32'h24; req_valid[2] = 1'b1;
        for (int k = 0; k < 20 && !gr; k++) begin
            @(negedge PCLK);
            if (req_ready[2]) gr = 1'b1;
        end
        req_valid[2] = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++;
        if (!gr || PENABLE !== 1'b1) begin
            errors++; $display("FAIL rstmid_access: got granted=%0d PENABLE=%b exp 1/1", gr, PENABLE);
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || resp_valid !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got PSEL=%b PENABLE=%b rv=%b exp 0/0/0",
                               PSEL, PENABLE, resp_valid);
        end
        PRESET = 1'b0;
        hang = 1'b0;
        repeat (10) begin
            @(negedge PCLK);
            if (resp_valid[2]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rstmid_no_resp: got resp_valid[2]=1 exp 0");
        end
        for (int i = 0; i < 4; i++) begin
            req_write[i] = 1'b0; req_addr[i] = 32'h80 + 4 * i;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 10 && first < 0; k++) begin
            @(negedge PCLK);
            if (req_ready != '0) first = idx_of(req_ready);
        end
        req_valid = '0;
        checks++;
        if (first != 0) begin
            errors++; $display("FAIL rstmid_ptr: got first grant %0d exp 0", first);
        end
        idle_bus();
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [256];
        int          rstate [4];
        int          age [4];
        logic [31:0] exp_rd [4];
        logic        exp_er [4];
        logic [3:0]  prev_valid = '0;
        int mptr = 0; int n_gr = 0; int n_rs = 0; int g; int e; int pend = 0;
        logic [31:0] tmp; logic [7:0] a;
        apply_reset(2);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 4; i++) begin rstate[i] = 0; age[i] = 0; end
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge PCLK);
            for (int i = 0; i < 4; i++) begin
                if (resp_valid[i]) begin
                    n_rs++;
                    checks++;
                    if (rstate[i] != 2 || resp_rdata !== exp_rd[i] || resp_err !== exp_er[i]) begin
                        errors++;
                        $display("FAIL rand_resp[%0d]: got st=%0d rd=%h err=%b exp 2/%h/%b",
                                 i, rstate[i], resp_rdata, resp_err, exp_rd[i], exp_er[i]);
                    end
                    rstate[i] = 0;
                end
            end
            if (req_ready != '0) begin
                g = idx_of(req_ready);
                e = pick(prev_valid, mptr);
                n_gr++;
                checks++;
                if (g != e || rstate[g] != 1) begin
                    errors++; $display("FAIL rand_grant: got %0d (st=%0d) exp %0d", g, rstate[g], e);
                end
                mptr = (g + 1) % 4;
                a = req_addr[g][7:0];
                exp_er[g] = (a >= 8'hF0);
                if (req_write[g]) begin
                    exp_rd[g] = '0;
                    if (!exp_er[g]) ref_mem[a] = req_wdata[g];
                end else begin
                    exp_rd[g] = ref_mem[a];
                end
                rstate[g] = 2; age[g] = 0; req_valid[g] = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (rstate[i] == 2) begin
                    age[i]++;
                    if (age[i] > 14) begin
                        checks++; errors++;
                        $display("FAIL rand_timeout[%0d]: got no response after %0d cycles exp <=14", i, age[i]);
                        rstate[i] = 0;
                    end
                end else if (rstate[i] == 1 && (cyc >= 440 || $urandom_range(0, 15) == 0)) begin
                    req_valid[i] = 1'b0; rstate[i] = 0;
                end else if (rstate[i] == 0 && cyc < 440 && $urandom_range(0, 2) == 0) begin
                    tmp = $urandom;
                    req_write[i] = tmp[0];
                    req_addr[i]  = {tmp[31:8], tmp[7:2], 2'b00};
                    req_wdata[i] = $urandom;
                    req_valid[i] = 1'b1;
                    rstate[i] = 1;
                end
            end
            wait_cfg = $urandom_range(0, 2);
            prev_valid = req_valid;
        end
        for (int i = 0; i < 4; i++) if (rstate[i] != 0) pend++;
        checks++;
        if (pend != 0 || n_rs != n_gr || n_gr < 30) begin
            errors++; $display("FAIL rand_drain: got pending=%0d resp=%0d grants=%0d exp 0/equal/>=30",
                               pend, n_rs, n_gr);
        end
        wait_cfg = 0;
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
